piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in/serial-out stage that accepts a WIDTH-bit word from an upstream parallel register bank and shifts it out one bit per clock with framing and completion signals. It sits directly downstream of the parallel-in/parallel-out flip-flop register. It converts that register's held word into a serial stream for a single-wire consumer.

## Interface
- WIDTH, 8, data word width; legal range 2..32
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted first; 0 = bit 0 is shifted first
- clk_i  in  1  clock; all state changes on its rising edge
- rst_i  in  1  reset; synchronous, active-high
- data_i  in  WIDTH  parallel word, sampled only on an accepted load
- load_i  in  1  load request; accepted only when ready_o=1
- ready_o  out  1  block idle and able to accept a load
- busy_o  out  1  frame in progress (SHIFT or PARITY state)
- serial_o  out  1  serial data bit
- frame_o  out  1  serial_o carries a valid frame bit this cycle
- done_o  out  1  single-cycle pulse after the last frame bit

## Operation
- All outputs are registered; no combinational input-to-output paths.
- Reset values: ready_o=1, busy_o=0, serial_o=0, frame_o=0, done_o=0, shift register=0, bit counter=0, state=IDLE.
- FSM states: IDLE, SHIFT, PARITY (only with macro), DONE.
- IDLE: ready_o=1, serial_o=0, frame_o=0. If load_i=1, capture data_i into the shift register, clear the counter, and go to SHIFT.
- SHIFT: serial_o is the current head bit, frame_o=1, busy_o=1. Each cycle the register shifts toward the head (left if MSB_FIRST, else right; vacated bit fills with 0) and the counter increments.
- SHIFT exit: when counter==WIDTH-1, go to PARITY if enabled, else DONE.
- DONE: one cycle; done_o=1, frame_o=0, busy_o=0, ready_o=0, serial_o=0. Next state is IDLE.
- Counter width is $clog2(WIDTH). It never exceeds WIDTH-1, with no wrap within a frame.
- load_i is ignored in SHIFT, PARITY and DONE. A word is never queued or overwritten mid-frame.
- rst_i=1 mid-frame aborts the frame. All outputs take their reset values on that edge, and no done_o is produced.
- rst_i and load_i asserted together: reset wins and nothing is captured.
- data_i changes after acceptance do not affect the frame in flight.

## Timing
- Load is accepted at rising edge E0 (load_i=1, ready_o=1).
- Data bits appear on serial_o in cycles E0+1 .. E0+WIDTH, with frame_o=1.
- Parity bit, if enabled, appears in cycle E0+WIDTH+1.
- done_o is high for exactly one cycle: E0+WIDTH+1 without parity, E0+WIDTH+2 with parity.
- ready_o returns to 1 the cycle after done_o. The minimum load-to-load spacing is WIDTH+2 cycles (WIDTH+3 with parity).
- ready_o falls in cycle E0+1.

## Configuration
- Macro: PISO_PARITY_EN.
- Defined: the PARITY state is compiled in. After the last data bit, one extra cycle drives serial_o = XOR of the captured word (even parity) with frame_o=1 and busy_o=1. The parity value is computed at capture and held in a 1-bit register.
- Undefined: no PARITY state and no parity register. The frame is exactly WIDTH bits.

## Structure
- Package piso_pkg holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2, DONE=2'd3);
  - a function returning the counter width from WIDTH.
- One sub-module, piso_bit_counter: a synchronous clear/enable counter with a terminal-count flag at WIDTH-1, reset by rst_i.
- The top level contains the FSM, the shift register and the output registers.

## Test plan
- Reset then idle: hold rst_i 3 cycles → ready_o=1, serial_o=0, frame_o=0, busy_o=0, done_o=0. No activity for 10 cycles.
- WIDTH=8, MSB_FIRST=1, load 8'hA5 at E0 → serial_o = 1,0,1,0,0,1,0,1 in E0+1..E0+8 with frame_o=1; done_o=1 only in E0+9; ready_o=1 in E0+10.
- MSB_FIRST=0, load 8'h01 → serial_o = 1,0,0,0,0,0,0,0. A second load 8'h3C at E0+3 is ignored, and the bit stream is unchanged.
- Reset mid-frame: load 8'hFF, assert rst_i in E0+4 → all outputs at reset values from the next edge, no done_o, and ready_o=1.
- With PISO_PARITY_EN: load 8'hA5 → parity bit 0 in E0+9, done_o in E0+10; load 8'h07 → parity bit 1.
- rst_i and load_i high in the same cycle with data 8'h55 → nothing captured, frame_o stays 0 for the next 10 cycles.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
// State encoding and counter sizing helper used by piso_serializer and piso_bit_counter.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  // WIDTH is at least 2, but keep the counter at least one bit wide regardless.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: synchronous clear/enable, saturates at WIDTH-1 and flags that terminal count.
module piso_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CW-1:0] count;

  assign last = (count == CW'(WIDTH - 1));

  // Holding at the terminal count keeps the counter from wrapping inside a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with framing and a done pulse; all outputs registered.
// Optional even-parity bit after the data bits is enabled by defining PISO_PARITY_EN.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             load_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             serial_o,
  output logic             frame_o,
  output logic             done_o
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             count_en;
  logic             count_last;
`ifdef PISO_PARITY_EN
  logic             parity_reg;
`endif

  assign accept   = (state == IDLE) && load_i;
  assign count_en = (state == SHIFT);

  // The head bit is whichever end leaves first; the vacated end fills with zero.
  always_comb begin
    shifted = '0;
    if (MSB_FIRST != 0) begin
      shifted = {shift_reg[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, shift_reg[WIDTH-1:1]};
    end
  end

  function automatic logic head(input logic [WIDTH-1:0] word);
    return (MSB_FIRST != 0) ? word[WIDTH-1] : word[0];
  endfunction

  piso_bit_counter #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_bit_counter (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (accept),
    .enable(count_en),
    .last  (count_last)
  );

  // serial_o is loaded with the bit for the coming cycle, so the first bit shows right after the load edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      shift_reg <= '0;
      ready_o   <= 1'b1;
      busy_o    <= 1'b0;
      serial_o  <= 1'b0;
      frame_o   <= 1'b0;
      done_o    <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load_i) begin
            state     <= SHIFT;
            shift_reg <= data_i;
            serial_o  <= head(data_i);
            frame_o   <= 1'b1;
            busy_o    <= 1'b1;
            ready_o   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_reg <= ^data_i;
`endif
          end
        end
        SHIFT: begin
          shift_reg <= shifted;
          if (count_last) begin
`ifdef PISO_PARITY_EN
            state    <= PARITY;
            serial_o <= parity_reg;
`else
            state    <= DONE;
            serial_o <= 1'b0;
            frame_o  <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
`endif
          end else begin
            serial_o <= head(shifted);
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state    <= DONE;
          serial_o <= 1'b0;
          frame_o  <= 1'b0;
          busy_o   <= 1'b0;
          done_o   <= 1'b1;
        end
`endif
        DONE: begin
          state   <= IDLE;
          done_o  <= 1'b0;
          ready_o <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          serial_o <= 1'b0;
          frame_o  <= 1'b0;
          busy_o   <= 1'b0;
          done_o   <= 1'b0;
          ready_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: one MSB-first and one LSB-first instance, WIDTH=8.
// Honours PISO_PARITY_EN when the design is built with it.
module tb_piso_serializer;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       load;
  logic [WIDTH-1:0] data [2];
  logic [1:0]       ready, busy, serial, frame, done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Index 0 shifts bit 0 first, index 1 shifts bit WIDTH-1 first.
  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
    .clk_i   (clk),
    .rst_i   (rst),
    .data_i  (data[0]),
    .load_i  (load[0]),
    .ready_o (ready[0]),
    .busy_o  (busy[0]),
    .serial_o(serial[0]),
    .frame_o (frame[0]),
    .done_o  (done[0])
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_msb (
    .clk_i   (clk),
    .rst_i   (rst),
    .data_i  (data[1]),
    .load_i  (load[1]),
    .ready_o (ready[1]),
    .busy_o  (busy[1]),
    .serial_o(serial[1]),
    .frame_o (frame[1]),
    .done_o  (done[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input int u, input string tag);
    checkOutput($sformatf("%s ready u%0d", tag, u), ready[u], 1);
    checkOutput($sformatf("%s busy u%0d", tag, u), busy[u], 0);
    checkOutput($sformatf("%s serial u%0d", tag, u), serial[u], 0);
    checkOutput($sformatf("%s frame u%0d", tag, u), frame[u], 0);
    checkOutput($sformatf("%s done u%0d", tag, u), done[u], 0);
  endtask

  // Reference: the frame is the word's bits in shift order, then even parity if enabled.
  task automatic applyStimulus(input int u, input logic [WIDTH-1:0] word, input int intrude);
    logic exp_q[$];
    for (int i = 0; i < WIDTH; i++)
      exp_q.push_back((u == 1) ? word[WIDTH-1-i] : word[i]);
    if (PAR != 0) exp_q.push_back(^word);

    checkOutput($sformatf("ready before load u%0d", u), ready[u], 1);
    load[u] = 1'b1;
    data[u] = word;
    step();
    load[u] = 1'b0;
    data[u] = WIDTH'($urandom);
    checkOutput($sformatf("ready fall u%0d", u), ready[u], 0);
    for (int k = 0; k < WIDTH + PAR; k++) begin
      if (k == intrude) begin
        load[u] = 1'b1;
        data[u] = 8'h3C;
      end else begin
        load[u] = 1'b0;
      end
      checkOutput($sformatf("serial bit%0d word %0h u%0d", k, word, u), serial[u], exp_q.pop_front());
      checkOutput($sformatf("frame bit%0d u%0d", k, u), frame[u], 1);
      checkOutput($sformatf("busy bit%0d u%0d", k, u), busy[u], 1);
      checkOutput($sformatf("done early bit%0d u%0d", k, u), done[u], 0);
      step();
    end
    load[u] = 1'b0;
    checkOutput($sformatf("done pulse u%0d", u), done[u], 1);
    checkOutput($sformatf("done frame u%0d", u), frame[u], 0);
    checkOutput($sformatf("done busy u%0d", u), busy[u], 0);
    checkOutput($sformatf("done ready u%0d", u), ready[u], 0);
    checkOutput($sformatf("done serial u%0d", u), serial[u], 0);
    step();
    checkIdle(u, "after done");
  endtask

  initial begin
    rst     = 1'b1;
    load    = 2'b00;
    data[0] = '0;
    data[1] = '0;

    repeat (3) step();
    checkIdle(0, "reset");
    checkIdle(1, "reset");
    rst = 1'b0;
    repeat (10) begin
      step();
      checkOutput("idle frame u0", frame[0], 0);
      checkOutput("idle frame u1", frame[1], 0);
      checkOutput("idle ready u1", ready[1], 1);
    end

    applyStimulus(1, 8'hA5, -1);
    applyStimulus(0, 8'h01, 2);
    applyStimulus(1, 8'h07, -1);
    applyStimulus(0, 8'hA5, -1);

    // Reset in cycle E0+4 aborts the frame with no done pulse.
    load[1] = 1'b1;
    data[1] = 8'hFF;
    step();
    load[1] = 1'b0;
    repeat (3) step();
    checkOutput("pre-abort frame", frame[1], 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkIdle(1, "abort");
    repeat (12) begin
      step();
      checkOutput("abort no done", done[1], 0);
      checkOutput("abort no frame", frame[1], 0);
    end

    // Reset wins over a simultaneous load.
    rst     = 1'b1;
    load    = 2'b11;
    data[0] = 8'h55;
    data[1] = 8'h55;
    step();
    rst  = 1'b0;
    load = 2'b00;
    repeat (10) begin
      step();
      checkOutput("rst+load frame u0", frame[0], 0);
      checkOutput("rst+load frame u1", frame[1], 0);
      checkOutput("rst+load ready u1", ready[1], 1);
    end

    for (int n = 0; n < 24; n++) begin
      int u;
      int gap;
      int intrude;
      u       = int'($urandom_range(0, 1));
      gap     = int'($urandom_range(0, 3));
      intrude = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, WIDTH - 1)) : -1;
      repeat (gap) begin
        step();
        checkOutput("gap ready", ready[u], 1);
      end
      applyStimulus(u, WIDTH'($urandom), intrude);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
